matvec_mac_engine: RTL and testbench
====================================

# matvec_mac_engine

Parametrised, time-multiplexed fixed-point matrix-vector engine computing y = M·x, y = b + M·x or y = b − M·x for an arbitrary ROWS×COLS matrix. It uses LANES parallel multiply-accumulate lanes with valid/ready handshakes, round-to-nearest and optional saturation. It is the shared arithmetic engine for Kalman predict (F·x), measurement projection (H·x) and innovation (z − H·x) in the NX-MIMOSA tracker datapath.

## Interface
- ROWS, default STATE_DIM: matrix rows and output vector length (≥1).
- COLS, default STATE_DIM: matrix columns and input vector length (≥1).
- LANES, default STATE_DIM: parallel MAC lanes (1..ROWS).
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand set valid.
- in_ready  out  1  engine can accept operands; high only in IDLE.
- in_op  in  mv_op_e  operation: MV_MUL=00, MV_ADD=01, MV_SUB=10; 11 executes as MV_MUL.
- in_m  in  fp_t [ROWS][COLS]  matrix M.
- in_x  in  fp_t [COLS]  vector x.
- in_b  in  fp_t [ROWS]  offset vector b; ignored for MV_MUL.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts result.
- out_y  out  fp_t [ROWS]  result vector; stable while out_valid.
- out_sat  out  1  at least one element of out_y saturated; valid with out_valid.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, MAC, ROUND, OUT.
- IDLE: when in_valid is high, register in_m, in_x, in_b and in_op; clear the accumulators and set grp=0, col=0; go to MAC.
- MAC: each cycle, lane l handles row r = grp·LANES + l (lanes with r ≥ ROWS idle): acc[l] += M[r][col]·x[col]. col increments each cycle. When col = COLS−1, go to ROUND.
- ROUND: for each active lane, form s = acc (MUL), acc + (b[r]<<FRAC_BITS) (ADD) or (b[r]<<FRAC_BITS) − acc (SUB).
  - Then res = (s + 2^(FRAC_BITS−1)) >>> FRAC_BITS, i.e. round half toward +∞.
  - Write res to out_y[r] and OR any saturation event into the sticky sat flag.
  - If grp is the last group, go to OUT. Otherwise increment grp, clear col and the accumulators, and return to MAC.
- OUT: out_valid=1. When out_ready is high, go to IDLE. The sat flag is cleared on the next accept.
- Groups: G = ceil(ROWS/LANES).
- Accumulator width: 2·DATA_WIDTH + clog2(COLS) + 2 signed, so it never overflows internally.
- Products are signed DATA_WIDTH×DATA_WIDTH, Q(2·FRAC_BITS).
- in_valid outside IDLE is ignored; operands are not re-sampled.
- Reset mid-operation: all state is discarded immediately and the engine goes to IDLE. There is no partial output.
- Reset values: out_y all 0, out_valid 0, out_sat 0, busy 0, in_ready 0 while rst_n is low. in_ready becomes 1 in IDLE after release.

## Timing
- Acceptance edge: the clk edge with in_valid & in_ready.
- out_valid rises G·(COLS+1) cycles after the acceptance edge. Default 4×4, LANES=4: 5 cycles.
- One transaction in flight. The next in_ready is high the cycle after the out_valid & out_ready edge.
- Minimum initiation interval: G·(COLS+1)+2 cycles.
- out_y and out_sat must not change while out_valid is high and out_ready is low.
- All outputs are registered or decoded from the state register. No combinational path from in_* to out_*.

## Configuration
- NX_MVE_SAT_EN defined:
  - In ROUND, res outside [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] clamps to the nearest bound.
  - out_sat is set when this happens.
- NX_MVE_SAT_EN undefined:
  - res is truncated to its low DATA_WIDTH bits (two's-complement wrap).
  - out_sat is tied to 0 and the saturation logic is absent.

## Structure
- nx_mimosa_pkg gains typedef enum logic [1:0] mv_op_e {MV_MUL, MV_ADD, MV_SUB, MV_RSVD}.
- The engine uses the package's existing DATA_WIDTH, FRAC_BITS, fp_t and STATE_DIM.
- Sub-module mve_mac_lane: one signed multiplier plus accumulator with synchronous clear and enable, instantiated LANES times with a generate loop, one DSP per lane.
- FSM, operand registers, row/column counters and the round/saturate stage live in the top module.

## Test plan
Q16.16 format (DATA_WIDTH=32, FRAC_BITS=16) unless noted.
- Identity pass-through: default 4×4, MV_MUL, M=I, x=[1.0, 2.0, −3.0, 0.5] -> out_y = x, out_valid exactly 5 cycles after accept, out_sat=0.
- Rounding: M[0][0]=0x00008000 (0.5), x[0]=0x00000001, others 0 -> out_y[0]=0x00000001; with x[0]=0xFFFFFFFF -> out_y[0]=0x00000000.
- Innovation mode: MV_SUB, M=I, x=[0.25]×4, b=[1.0]×4 -> out_y=[0.75]×4 (0x0000C000).
- Saturation: M row0 = [100.0]×4, x=[100.0]×4 -> with NX_MVE_SAT_EN, out_y[0]=0x7FFFFFFF and out_sat=1; without it, out_y[0] = wrapped low 32 bits and out_sat=0.
- Multi-group plus backpressure: ROWS=3, COLS=6, LANES=1, random operands checked against a golden model:
  - out_valid after 21 cycles.
  - Hold out_ready low for 10 cycles: out_y stable, in_ready=0, a second in_valid is ignored.
- Reset mid-MAC: assert rst_n low 2 cycles into MAC -> all outputs 0 immediately. After release, in_ready=1 and a fresh identity transaction completes correctly.

Source files
------------

// File: rtl/nx_mimosa_pkg.sv
// nx_mimosa_pkg
// Shared fixed-point types and constants for the NX-MIMOSA tracker datapath.
// Q16.16 fixed point (fp_t), the state-vector dimension, the matrix-vector
// engine operation codes and the engine's FSM state type.
package nx_mimosa_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int FRAC_BITS  = 16;
    localparam int STATE_DIM  = 4;

    typedef logic signed [DATA_WIDTH-1:0] fp_t;

    typedef enum logic [1:0] {
        MV_MUL  = 2'b00,
        MV_ADD  = 2'b01,
        MV_SUB  = 2'b10,
        MV_RSVD = 2'b11
    } mv_op_e;

    typedef enum logic [1:0] {
        MVE_IDLE  = 2'b00,
        MVE_MAC   = 2'b01,
        MVE_ROUND = 2'b10,
        MVE_OUT   = 2'b11
    } mve_state_e;

    // Accumulator width that holds a full COLS-term dot product of
    // DATA_WIDTH x DATA_WIDTH products without internal overflow.
    function automatic int mve_acc_width(input int cols);
        return 2 * DATA_WIDTH + $clog2(cols) + 2;
    endfunction

endpackage

// File: rtl/mve_mac_lane.sv
// mve_mac_lane
// One multiply-accumulate lane of the matrix-vector engine: a single signed
// DATA_WIDTH x DATA_WIDTH multiplier feeding an ACC_W-bit accumulator.
// Ports:
//   clk  - clock
//   clr  - synchronous clear of the accumulator (wins over en)
//   en   - accumulate a*b this cycle
//   a, b - signed fixed-point operands
//   acc  - running accumulator, Q(2*FRAC_BITS)
import nx_mimosa_pkg::*;

module mve_mac_lane #(
    parameter int ACC_W = mve_acc_width(STATE_DIM)
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    en,
    input  fp_t                     a,
    input  fp_t                     b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*DATA_WIDTH-1:0] prod_p0;

    assign prod_p0 = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);

    // p0 -> p1: accumulate
    always_ff @(posedge clk) begin
        if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod_p0);
        end
    end

endmodule

// File: rtl/matvec_mac_engine.sv
// matvec_mac_engine
// Time-multiplexed fixed-point matrix-vector engine: y = M*x, b + M*x or
// b - M*x for a ROWS x COLS matrix, using LANES parallel MAC lanes. Rows are
// processed in groups of LANES; each group takes COLS MAC cycles plus one
// ROUND cycle. Results are rounded half toward +inf.
// Optional feature macro: NX_MVE_SAT_EN - clamp results to the fp_t range and
// report it on out_sat; otherwise results wrap and out_sat is 0.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (ready only in IDLE)
//   in_op, in_m, in_x, in_b - operation, matrix, vector, offset vector
//   out_valid/out_ready - result handshake (valid held until ready)
//   out_y, out_sat      - result vector and sticky saturation flag
//   busy                - engine not in IDLE
import nx_mimosa_pkg::*;

module matvec_mac_engine #(
    parameter int ROWS  = STATE_DIM,
    parameter int COLS  = STATE_DIM,
    parameter int LANES = STATE_DIM
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   in_valid,
    output logic   in_ready,
    input  mv_op_e in_op,
    input  fp_t    in_m [ROWS][COLS],
    input  fp_t    in_x [COLS],
    input  fp_t    in_b [ROWS],
    output logic   out_valid,
    input  logic   out_ready,
    output fp_t    out_y [ROWS],
    output logic   out_sat,
    output logic   busy
);

    localparam int G     = (ROWS + LANES - 1) / LANES;
    localparam int ACC_W = mve_acc_width(COLS);
    localparam int SUM_W = ACC_W + 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int GRP_W = (G > 1) ? $clog2(G) : 1;

    localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) <<< (FRAC_BITS - 1);

    mve_state_e        state;
    logic [COL_W-1:0]  col;
    logic [GRP_W-1:0]  grp;

    fp_t    m_q [ROWS][COLS];
    fp_t    x_q [COLS];
    fp_t    b_q [ROWS];
    mv_op_e op_q;

    logic accept;
    logic last_grp;
    logic lane_clr;

    logic signed [ACC_W-1:0] acc [LANES];
    fp_t                     rnd_y [ROWS];
    logic [ROWS-1:0]         row_sel;

    assign accept   = in_valid & in_ready;
    assign last_grp = (grp == GRP_W'(G - 1));
    assign lane_clr = accept | ((state == MVE_ROUND) & ~last_grp);

    // Pre-round sum in the accumulator's Q(2*FRAC_BITS) scale.
    function automatic logic signed [SUM_W-1:0] form_sum(
        input mv_op_e                  op,
        input logic signed [ACC_W-1:0] a,
        input fp_t                     b
    );
        logic signed [SUM_W-1:0] bs;
        bs = SUM_W'(b) <<< FRAC_BITS;
        case (op)
            MV_ADD:  return SUM_W'(a) + bs;
            MV_SUB:  return bs - SUM_W'(a);
            default: return SUM_W'(a);
        endcase
    endfunction

    function automatic logic signed [SUM_W-1:0] round_half_up(
        input logic signed [SUM_W-1:0] s
    );
        return (s + HALF) >>> FRAC_BITS;
    endfunction

`ifdef NX_MVE_SAT_EN
    localparam logic signed [SUM_W-1:0] FP_MAX =
        {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] FP_MIN =
        {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    function automatic fp_t fit(input logic signed [SUM_W-1:0] r);
        if (r > FP_MAX) return FP_MAX[DATA_WIDTH-1:0];
        if (r < FP_MIN) return FP_MIN[DATA_WIDTH-1:0];
        return r[DATA_WIDTH-1:0];
    endfunction

    function automatic logic sat_hit(input logic signed [SUM_W-1:0] r);
        return (r > FP_MAX) || (r < FP_MIN);
    endfunction

    logic            sat_q;
    logic [ROWS-1:0] rnd_sat;

    assign out_sat = sat_q;
`else
    function automatic fp_t fit(input logic signed [SUM_W-1:0] r);
        return r[DATA_WIDTH-1:0];
    endfunction

    assign out_sat = 1'b0;
`endif

    // Lane l serves rows l, l+LANES, ...; only the row in the current group
    // drives the lane, rows past ROWS leave it idle.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fp_t  a_l;
        logic en_l;

        always_comb begin
            a_l  = '0;
            en_l = 1'b0;
            for (int r = l; r < ROWS; r += LANES) begin
                if (r / LANES == int'(grp)) begin
                    a_l  = m_q[r][col];
                    en_l = (state == MVE_MAC);
                end
            end
        end

        mve_mac_lane #(.ACC_W(ACC_W)) u_lane (
            .clk (clk),
            .clr (lane_clr),
            .en  (en_l),
            .a   (a_l),
            .b   (x_q[col]),
            .acc (acc[l])
        );
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_sel[r] = (r / LANES == int'(grp));
            rnd_y[r]   = fit(round_half_up(form_sum(op_q, acc[r % LANES], b_q[r])));
`ifdef NX_MVE_SAT_EN
            rnd_sat[r] = sat_hit(round_half_up(form_sum(op_q, acc[r % LANES], b_q[r])));
`endif
        end
    end

    // Operand capture at the acceptance edge
    always_ff @(posedge clk) begin
        if (accept) begin
            m_q  <= in_m;
            x_q  <= in_x;
            b_q  <= in_b;
            op_q <= in_op;
        end
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MVE_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            col       <= '0;
            grp       <= '0;
            for (int r = 0; r < ROWS; r++) out_y[r] <= '0;
`ifdef NX_MVE_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            case (state)
                MVE_IDLE: begin
                    if (accept) begin
                        state    <= MVE_MAC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        col      <= '0;
                        grp      <= '0;
`ifdef NX_MVE_SAT_EN
                        sat_q    <= 1'b0;
`endif
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                MVE_MAC: begin
                    if (col == COL_W'(COLS - 1)) begin
                        state <= MVE_ROUND;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                MVE_ROUND: begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (row_sel[r]) out_y[r] <= rnd_y[r];
                    end
`ifdef NX_MVE_SAT_EN
                    sat_q <= sat_q | (|(rnd_sat & row_sel));
`endif
                    if (last_grp) begin
                        state     <= MVE_OUT;
                        out_valid <= 1'b1;
                    end else begin
                        state <= MVE_MAC;
                        grp   <= grp + 1'b1;
                        col   <= '0;
                    end
                end
                default: begin
                    if (out_ready) begin
                        state     <= MVE_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_mac_engine.sv
// tb_matvec_mac_engine
// Self-checking bench for matvec_mac_engine: a default 4x4/4-lane instance
// and a 3x6/1-lane instance, checked against an arithmetic reference model.
// Honours NX_MVE_SAT_EN for the expected saturation behaviour.
import nx_mimosa_pkg::*;

module tb_matvec_mac_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic   a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat, a_busy;
    mv_op_e a_op;
    fp_t    a_m [4][4];
    fp_t    a_x [4];
    fp_t    a_b [4];
    fp_t    a_y [4];
    logic [31:0] a_exp [4];
    logic        a_exp_sat;

    logic   b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat, b_busy;
    mv_op_e b_op;
    fp_t    b_m [3][6];
    fp_t    b_x [6];
    fp_t    b_b [3];
    fp_t    b_y [3];
    logic [31:0] b_exp [3];
    logic        b_exp_sat;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    matvec_mac_engine dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_op),
        .in_m(a_m), .in_x(a_x), .in_b(a_b),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_y(a_y), .out_sat(a_out_sat), .busy(a_busy)
    );

    matvec_mac_engine #(.ROWS(3), .COLS(6), .LANES(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_op),
        .in_m(b_m), .in_x(b_x), .in_b(b_b),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_y(b_y), .out_sat(b_out_sat), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact dot product in wide integers, then the rounding/range rules.
    function automatic logic [32:0] ref_row(input int n, input mv_op_e op,
                                            input fp_t mr [6], input fp_t xv [6],
                                            input fp_t bb);
        logic signed [127:0] s, t, u, bx;
        s = 0;
        for (int i = 0; i < n; i++) begin
            t = mr[i];
            u = xv[i];
            s = s + t * u;
        end
        bx = bb;
        bx = bx * 65536;
        if (op == MV_ADD)      s = s + bx;
        else if (op == MV_SUB) s = bx - s;
        s = (s + 32768) >>> 16;
`ifdef NX_MVE_SAT_EN
        if (s > 128'sh7FFFFFFF)  return {1'b1, 32'h7FFFFFFF};
        if (s < -128'sh80000000) return {1'b1, 32'h80000000};
`endif
        return {1'b0, s[31:0]};
    endfunction

    task automatic calc_a();
        fp_t mr [6];
        fp_t xv [6];
        logic [32:0] e;
        a_exp_sat = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 6; i++) begin
                mr[i] = '0;
                xv[i] = '0;
                if (i < 4) begin
                    mr[i] = a_m[r][i];
                    xv[i] = a_x[i];
                end
            end
            e = ref_row(4, a_op, mr, xv, a_b[r]);
            a_exp[r]  = e[31:0];
            a_exp_sat = a_exp_sat | e[32];
        end
    endtask

    task automatic calc_b();
        fp_t mr [6];
        fp_t xv [6];
        logic [32:0] e;
        b_exp_sat = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) begin
                mr[i] = b_m[r][i];
                xv[i] = b_x[i];
            end
            e = ref_row(6, b_op, mr, xv, b_b[r]);
            b_exp[r]  = e[31:0];
            b_exp_sat = b_exp_sat | e[32];
        end
    endtask

    task automatic set_identity_a();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                a_m[r][c] = (r == c) ? 32'sh0001_0000 : 32'sh0;
    endtask

    task automatic clear_a();
        for (int r = 0; r < 4; r++) begin
            a_x[r] = '0;
            a_b[r] = '0;
            for (int c = 0; c < 4; c++) a_m[r][c] = '0;
        end
    endtask

    task automatic rand_a(input int shift);
        fp_t v;
        a_op = mv_op_e'(2'($urandom_range(0, 3)));
        for (int r = 0; r < 4; r++) begin
            v = $urandom; a_x[r] = v >>> shift;
            v = $urandom; a_b[r] = v >>> shift;
            for (int c = 0; c < 4; c++) begin
                v = $urandom; a_m[r][c] = v >>> shift;
            end
        end
    endtask

    task automatic rand_b(input int shift);
        fp_t v;
        b_op = mv_op_e'(2'($urandom_range(0, 3)));
        for (int c = 0; c < 6; c++) begin
            v = $urandom; b_x[c] = v >>> shift;
        end
        for (int r = 0; r < 3; r++) begin
            v = $urandom; b_b[r] = v >>> shift;
            for (int c = 0; c < 6; c++) begin
                v = $urandom; b_m[r][c] = v >>> shift;
            end
        end
    endtask

    // Accept one transaction on dut_a (out_ready held high) and check it.
    task automatic run_a(input string tag);
        calc_a();
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(a_in_ready), 32'd1);
        a_in_valid = 1'b1;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd5);
        for (int r = 0; r < 4; r++)
            chk($sformatf("%s_y%0d", tag, r), a_y[r], a_exp[r]);
        chk({tag, "_sat"}, 32'(a_out_sat), 32'(a_exp_sat));
        @(posedge clk);
        #1;
        chk({tag, "_ready_after"}, 32'(a_in_ready), 32'd1);
        chk({tag, "_valid_after"}, 32'(a_out_valid), 32'd0);
    endtask

    // Accept one transaction on dut_b and wait for its result.
    task automatic start_b(input string tag);
        calc_b();
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(b_in_ready), 32'd1);
        b_in_valid = 1'b1;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd21);
        for (int r = 0; r < 3; r++)
            chk($sformatf("%s_y%0d", tag, r), b_y[r], b_exp[r]);
        chk({tag, "_sat"}, 32'(b_out_sat), 32'(b_exp_sat));
    endtask

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        b_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        a_op        = MV_MUL;
        b_op        = MV_MUL;
        clear_a();
        for (int r = 0; r < 3; r++) begin
            b_b[r] = '0;
            for (int c = 0; c < 6; c++) b_m[r][c] = '0;
        end
        for (int c = 0; c < 6; c++) b_x[c] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(a_in_ready), 32'd0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_out_sat", 32'(a_out_sat), 32'd0);
        chk("rst_b_in_ready", 32'(b_in_ready), 32'd0);
        for (int r = 0; r < 4; r++) chk($sformatf("rst_y%0d", r), a_y[r], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(a_in_ready), 32'd1);
        chk("rel_b_in_ready", 32'(b_in_ready), 32'd1);

        // Identity pass-through
        set_identity_a();
        a_op  = MV_MUL;
        a_x[0] = 32'sh0001_0000; a_x[1] = 32'sh0002_0000;
        a_x[2] = -32'sh0003_0000; a_x[3] = 32'sh0000_8000;
        run_a("ident");
        chk("ident_y2_const", a_y[2], 32'hFFFD_0000);

        // Rounding half toward +inf
        clear_a();
        a_m[0][0] = 32'sh0000_8000;
        a_x[0]    = 32'sh0000_0001;
        run_a("round_pos");
        chk("round_pos_const", a_y[0], 32'h0000_0001);
        a_x[0] = -32'sh1;
        run_a("round_neg");
        chk("round_neg_const", a_y[0], 32'h0000_0000);

        // Innovation, offset add and reserved op
        set_identity_a();
        for (int r = 0; r < 4; r++) begin
            a_x[r] = 32'sh0000_4000;
            a_b[r] = 32'sh0001_0000;
        end
        a_op = MV_SUB;
        run_a("sub");
        chk("sub_const", a_y[3], 32'h0000_C000);
        a_op = MV_ADD;
        run_a("add");
        chk("add_const", a_y[1], 32'h0001_4000);
        a_op = MV_RSVD;
        run_a("rsvd");
        chk("rsvd_const", a_y[0], 32'h0000_4000);

        // Saturation / wrap on row 0
        clear_a();
        a_op = MV_MUL;
        for (int c = 0; c < 4; c++) begin
            a_m[0][c] = 32'sh0064_0000;
            a_x[c]    = 32'sh0064_0000;
        end
        run_a("satur");
`ifdef NX_MVE_SAT_EN
        chk("satur_const", a_y[0], 32'h7FFF_FFFF);
        chk("satur_flag", 32'(a_out_sat), 32'd1);
`else
        chk("satur_const", a_y[0], 32'h9C40_0000);
        chk("satur_flag", 32'(a_out_sat), 32'd0);
`endif

        // Randomized transactions, moderate and full range
        for (int k = 0; k < 4; k++) begin
            rand_a(12);
            run_a($sformatf("rnd_mod%0d", k));
        end
        for (int k = 0; k < 2; k++) begin
            rand_a(0);
            run_a($sformatf("rnd_full%0d", k));
        end

        // Multi-group with backpressure and an ignored second request
        b_out_ready = 1'b0;
        rand_b(10);
        start_b("bp");
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                b_in_valid = 1'b1;
                rand_b(8);
            end
            if (k == 7) b_in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_valid", k), 32'(b_out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_ready", k), 32'(b_in_ready), 32'd0);
            for (int r = 0; r < 3; r++)
                chk($sformatf("bp_hold%0d_y%0d", k, r), b_y[r], b_exp[r]);
        end
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ready", 32'(b_in_ready), 32'd1);
        chk("bp_release_valid", 32'(b_out_valid), 32'd0);
        chk("bp_release_busy", 32'(b_busy), 32'd0);
        rand_b(10);
        start_b("grp2");
        rand_b(0);
        @(posedge clk);
        #1;
        start_b("grp3");
        @(posedge clk);
        #1;

        // Reset in the middle of MAC
        set_identity_a();
        a_op = MV_MUL;
        for (int r = 0; r < 4; r++) a_x[r] = 32'sh0000_1234 * (r + 1);
        @(negedge clk);
        a_in_valid = 1'b1;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy_before", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(a_busy), 32'd0);
        chk("mid_out_valid", 32'(a_out_valid), 32'd0);
        chk("mid_in_ready", 32'(a_in_ready), 32'd0);
        chk("mid_out_sat", 32'(a_out_sat), 32'd0);
        for (int r = 0; r < 4; r++) chk($sformatf("mid_y%0d", r), a_y[r], 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rel_ready", 32'(a_in_ready), 32'd1);
        run_a("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
